sram_bank_ctrl: RTL and testbench



---
 rtl/sram_bank_ctrl_pkg.sv | 22 ++
 rtl/sram_bank_ctrl_if.sv | 23 ++
 rtl/sram_bank_ctrl_timer.sv | 32 +++
 rtl/sram_bank_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sram_bank_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_bank_ctrl_pkg.sv
// Shared definitions for the multi-bank asynchronous SRAM controller:
// FSM state encoding and elaboration-time parameter helpers.
package sram_bank_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_SETUP  = 3'd1;
   localparam state_t ST_STROBE = 3'd2;
   localparam state_t ST_HOLD   = 3'd3;
   localparam state_t ST_WAIT   = 3'd4;

   function automatic bit params_ok(input int num_banks, input int read_wait,
                                    input int we_cycles);
      return (num_banks >= 1) && (read_wait >= 1) && (we_cycles >= 1);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sram_bank_ctrl_if.sv
// System-side request/response bus of the SRAM bank controller.
interface sram_bank_ctrl_if #(
   parameter int AW = 20,
   parameter int DW = 8
);
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sram_bank_ctrl_timer.sv
// Phase timer: down-counter loaded with (cycles-1) when SETUP exits,
// last_o marks the final cycle of the STROBE or WAIT phase.
module sram_cycle_timer #(
   parameter int TW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_i,
   input  logic [TW-1:0] load_val_i,
   output logic          last_o
);
   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_o = (cnt_q == '0);
endmodule

// File: rtl/sram_bank_ctrl.sv
// Multi-bank asynchronous SRAM controller: maps a linear address onto
// NUM_BANKS chips and sequences setup / write-strobe / hold / read-wait.
//
// state  | meaning
// IDLE   | ready for a request, address lines keep their last value
// SETUP  | address (and write data) driven, all WE_n high
// STROBE | WE_n of the selected bank low for WE_CYCLES cycles
// HOLD   | WE_n released, address and data still driven
// WAIT   | read access time, data captured on the last cycle
module sram_bank_ctrl
   import sram_bank_pkg::*;
#(
   parameter int NUM_BANKS = 2,
   parameter int BANK_AW   = 19,
   parameter int DW        = 8,
   parameter int READ_WAIT = 2,
   parameter int WE_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   sram_bank_ctrl_if.slave         bus,
   output logic [BANK_AW-1:0]      sram_a_o,
   output logic [NUM_BANKS-1:0]    sram_we_n_o,
   output logic [DW-1:0]           sram_dout_o,
   output logic [NUM_BANKS-1:0]    sram_doe_o,
   input  logic [NUM_BANKS*DW-1:0] sram_din_i
);
   localparam int BSW = $clog2(NUM_BANKS);
   localparam int AW  = BANK_AW + BSW;
   localparam int BW  = (BSW > 0) ? BSW : 1;
   localparam int TW  = $clog2(max2(READ_WAIT, WE_CYCLES) + 1);
   localparam logic [TW-1:0] WE_LOAD = TW'(WE_CYCLES - 1);
   localparam logic [TW-1:0] RD_LOAD = TW'(READ_WAIT - 1);

   if (!params_ok(NUM_BANKS, READ_WAIT, WE_CYCLES)) begin : g_param_err
      $error("sram_bank_ctrl: NUM_BANKS, READ_WAIT and WE_CYCLES must all be >= 1");
   end

   logic [BW-1:0] req_bank;
   if (BSW > 0) begin : g_bank
      assign req_bank = bus.req_addr[AW-1:BANK_AW];
   end else begin : g_nobank
      assign req_bank = '0;
   end

   state_t                 state_q, state_d;
   logic                   we_q, we_d;
   logic                   ok_q, ok_d;
   logic [BW-1:0]          bank_q, bank_d;
   logic [BANK_AW-1:0]     a_q, a_d;
   logic [DW-1:0]          dout_q, dout_d;
   logic [NUM_BANKS-1:0]   we_n_q, we_n_d;
   logic [NUM_BANKS-1:0]   doe_q, doe_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]          rdata_q, rdata_d;

   logic                   req_ok;
   logic [NUM_BANKS-1:0]   req_onehot, cur_onehot;
   logic [DW-1:0]          rd_sel;
   logic                   tmr_load, tmr_last;
   logic [TW-1:0]          tmr_val;

   // Bank indices past NUM_BANKS exist only for non-power-of-2 bank counts.
   assign req_ok     = (int'(req_bank) < NUM_BANKS);
   assign req_onehot = NUM_BANKS'(1) << req_bank;
   assign cur_onehot = NUM_BANKS'(1) << bank_q;
   assign tmr_load   = (state_q == ST_SETUP);
   assign tmr_val    = we_q ? WE_LOAD : RD_LOAD;

   sram_cycle_timer #(.TW(TW)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .last_o     (tmr_last)
   );

   always_comb begin
      rd_sel = '1;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (bank_q == BW'(b)) begin
            rd_sel = sram_din_i[b*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         ok_q        <= 1'b0;
         bank_q      <= '0;
         a_q         <= '0;
         dout_q      <= '0;
         we_n_q      <= '1;
         doe_q       <= '0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         ok_q        <= ok_d;
         bank_q      <= bank_d;
         a_q         <= a_d;
         dout_q      <= dout_d;
         we_n_q      <= we_n_d;
         doe_q       <= doe_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (bus.req_valid) state_d = ST_SETUP;
         ST_SETUP:  state_d = we_q ? ST_STROBE : ST_WAIT;
         ST_STROBE: if (tmr_last) state_d = ST_HOLD;
         ST_HOLD:   state_d = ST_IDLE;
         ST_WAIT:   if (tmr_last) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Pin values are computed one state ahead so every pad output is a flop.
   always_comb begin
      we_d        = we_q;
      ok_d        = ok_q;
      bank_d      = bank_q;
      a_d         = a_q;
      dout_d      = dout_q;
      we_n_d      = we_n_q;
      doe_d       = doe_q;
      rsp_valid_d = 1'b0;
      rdata_d     = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               we_d   = bus.req_we;
               ok_d   = req_ok;
               bank_d = req_bank;
               a_d    = bus.req_addr[BANK_AW-1:0];
               if (bus.req_we) begin
                  dout_d = bus.req_wdata;
                  if (req_ok) doe_d = req_onehot;
               end
            end
         end
         ST_SETUP: begin
            if (we_q && ok_q) we_n_d = ~cur_onehot;
         end
         ST_STROBE: begin
            if (tmr_last) we_n_d = '1;
         end
         ST_HOLD: begin
            doe_d       = '0;
            rsp_valid_d = 1'b1;
            rdata_d     = '0;
         end
         ST_WAIT: begin
            if (tmr_last) begin
               rsp_valid_d = 1'b1;
               rdata_d     = rd_sel;
            end
         end
         default: ;
      endcase
   end

   assign bus.req_ready = (state_q == ST_IDLE) && !reset;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign sram_a_o      = a_q;
   assign sram_we_n_o   = we_n_q;
   assign sram_dout_o   = dout_q;
   assign sram_doe_o    = doe_q;
endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Self-checking bench for sram_bank_ctrl: pin-level SRAM chip models plus a
// transaction-level reference memory and latency scoreboard.
module tb_sram_bank_ctrl;
   localparam int NB = 2, BAW = 19, DW = 8, RW = 2, WC = 2;
   localparam int AW  = BAW + 1;
   localparam int AW3 = BAW + 2;
   localparam int WR_LAT = 3 + WC;
   localparam int RD_LAT = 2 + RW;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_bank_ctrl_if #(.AW(AW),  .DW(DW)) bus ();
   sram_bank_ctrl_if #(.AW(AW3), .DW(DW)) bus3 ();

   logic [BAW-1:0]   sram_a;
   logic [NB-1:0]    we_n, doe;
   logic [DW-1:0]    dout;
   logic [NB*DW-1:0] din = '0;

   logic [BAW-1:0]   sram_a3;
   logic [2:0]       we_n3, doe3;
   logic [DW-1:0]    dout3;
   logic [3*DW-1:0]  din3 = 24'h12_11_10;

   sram_bank_ctrl #(.NUM_BANKS(NB), .BANK_AW(BAW), .DW(DW), .READ_WAIT(RW), .WE_CYCLES(WC)) u_dut (
      .clk(clk), .reset(reset), .bus(bus),
      .sram_a_o(sram_a), .sram_we_n_o(we_n), .sram_dout_o(dout),
      .sram_doe_o(doe), .sram_din_i(din));

   sram_bank_ctrl #(.NUM_BANKS(3), .BANK_AW(BAW), .DW(DW), .READ_WAIT(RW), .WE_CYCLES(WC)) u_dut3 (
      .clk(clk), .reset(reset), .bus(bus3),
      .sram_a_o(sram_a3), .sram_we_n_o(we_n3), .sram_dout_o(dout3),
      .sram_doe_o(doe3), .sram_din_i(din3));

   typedef struct { int cyc; logic [7:0] data; } exp_t;

   logic [7:0] pin_mem [int];
   logic [7:0] ref_mem [int];
   exp_t       exp_q [$];
   exp_t       rsp_log [$];
   int         rsp_count = 0;
   bit         cur_read = 0;
   logic [NB-1:0] prev_we_n = '1;

   function automatic int key_of(input int bank, input logic [BAW-1:0] a);
      return (bank << BAW) | int'(a);
   endfunction

   // Power-on content of the fake chips, shared by pin model and reference.
   function automatic logic [7:0] init_val(input int k);
      return 8'((k * 37) ^ (k >> 5));
   endfunction

   function automatic logic [7:0] ref_rd(input int k);
      return ref_mem.exists(k) ? ref_mem[k] : init_val(k);
   endfunction

   always @(negedge clk) begin : mon
      int   k;
      int   bk;
      exp_t e;
      if (reset) begin
         prev_we_n = '1;
         cur_read  = 0;
      end else begin
         checks++;
         if ($countones(~we_n) > 1 || $countones(doe) > 1 || (cur_read && doe != '0) ||
             ((~we_n & ~doe) != '0)) begin
            errors++;
            $display("FAIL pin_invariant cyc=%0d we_n=%b doe=%b read=%0d", cyc, we_n, doe, cur_read);
         end
         for (int b = 0; b < NB; b++) begin
            if (!prev_we_n[b] && we_n[b] && doe[b]) pin_mem[key_of(b, sram_a)] = dout;
         end
         prev_we_n = we_n;
         for (int b = 0; b < NB; b++) begin
            k = key_of(b, sram_a);
            din[b*DW +: DW] = doe[b] ? dout : (pin_mem.exists(k) ? pin_mem[k] : init_val(k));
         end
         if (bus.rsp_valid) begin
            rsp_count++;
            e.cyc = cyc; e.data = bus.rsp_rdata;
            rsp_log.push_back(e);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected cyc=%0d data=%h required=no response", cyc, bus.rsp_rdata);
            end else begin
               e = exp_q.pop_front();
               if (cyc !== e.cyc || bus.rsp_rdata !== e.data) begin
                  errors++;
                  $display("FAIL scoreboard cyc=%0d data=%h required cyc=%0d data=%h",
                           cyc, bus.rsp_rdata, e.cyc, e.data);
               end
            end
         end
         if (bus.req_valid && bus.req_ready) begin
            bk = int'(bus.req_addr[AW-1]);
            k  = key_of(bk, bus.req_addr[BAW-1:0]);
            if (bus.req_we) begin
               ref_mem[k] = bus.req_wdata;
               e.cyc = cyc + WR_LAT; e.data = 8'h00;
            end else begin
               e.cyc = cyc + RD_LAT; e.data = ref_rd(k);
            end
            exp_q.push_back(e);
            cur_read = !bus.req_we;
         end
      end
   end

   // Called and returns #1 after a rising edge; t = cycle in which the request was accepted.
   task automatic issue(input bit we, input logic [AW-1:0] addr, input logic [7:0] data, output int t);
      bit got = 0;
      t = -1;
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = data;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin got = 1; t = cyc; end
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL issue_timeout addr=%h ready=%b required=1", addr, bus.req_ready);
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.req_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready_high got=%b required=0", bus.req_ready);
      end
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_bus ready=%b rsp=%b rdata=%h required 1 0 00",
                  bus.req_ready, bus.rsp_valid, bus.rsp_rdata);
      end
      checks++;
      if (sram_a !== '0 || dout !== '0 || we_n !== 2'b11 || doe !== 2'b00) begin
         errors++;
         $display("FAIL reset_pins a=%h dout=%h we_n=%b doe=%b required 0 0 11 00", sram_a, dout, we_n, doe);
      end
      checks++;
      if (we_n3 !== 3'b111 || doe3 !== 3'b000 || bus3.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_dut3 we_n=%b doe=%b ready=%b required 111 000 1", we_n3, doe3, bus3.req_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_write_timing();
      int t;
      bit exp_doe, exp_wel;
      issue(1'b1, 20'h01234, 8'hA5, t);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         exp_doe = (k <= 2 + WC);
         exp_wel = (k >= 2 && k <= 1 + WC);
         checks++;
         if (cyc !== t + k || sram_a !== 19'h01234 || doe !== {1'b0, exp_doe} ||
             we_n !== {1'b1, ~exp_wel} || bus.rsp_valid !== (k == WR_LAT) ||
             (exp_doe && dout !== 8'hA5)) begin
            errors++;
            $display("FAIL write_timing k=%0d a=%h doe=%b we_n=%b rsp=%b dout=%h required doe0=%0d we_low=%0d rsp=%0d",
                     k, sram_a, doe, we_n, bus.rsp_valid, dout, exp_doe, exp_wel, (k == WR_LAT));
         end
      end
      wait_drain();
   endtask

   task automatic test_two_banks();
      int t, t1, t2;
      bit saw0 = 0, saw1 = 0;
      issue(1'b1, 20'h81234, 8'h5A, t);
      for (int k = 1; k <= WR_LAT; k++) begin
         @(negedge clk);
         if (!we_n[0]) saw0 = 1;
         if (!we_n[1]) saw1 = 1;
      end
      @(posedge clk); #1;
      checks++;
      if (saw0 || !saw1) begin
         errors++; $display("FAIL bank1_strobe saw0=%0d saw1=%0d required 0 1", saw0, saw1);
      end
      rsp_log.delete();
      issue(1'b0, 20'h01234, 8'h00, t1);
      issue(1'b0, 20'h81234, 8'h00, t2);
      wait_drain();
      checks++;
      if (rsp_log.size() != 2) begin
         errors++; $display("FAIL two_bank_rsp_count got=%0d required=2", rsp_log.size());
      end else begin
         checks++;
         if (rsp_log[0].data !== 8'hA5 || rsp_log[0].cyc != t1 + RD_LAT) begin
            errors++;
            $display("FAIL read_bank0 data=%h cyc=%0d required data=a5 cyc=%0d", rsp_log[0].data, rsp_log[0].cyc, t1 + RD_LAT);
         end
         checks++;
         if (rsp_log[1].data !== 8'h5A || rsp_log[1].cyc != t2 + RD_LAT) begin
            errors++;
            $display("FAIL read_bank1 data=%h cyc=%0d required data=5a cyc=%0d", rsp_log[1].data, rsp_log[1].cyc, t2 + RD_LAT);
         end
      end
   endtask

   task automatic test_oob();
      bit             tw   [3];
      logic [AW3-1:0] ta   [3];
      int             tlat [3];
      logic [7:0]     texp [3];
      tw[0] = 0; ta[0] = 21'h180000; tlat[0] = RD_LAT; texp[0] = 8'hFF;
      tw[1] = 1; ta[1] = 21'h180000; tlat[1] = WR_LAT; texp[1] = 8'h00;
      tw[2] = 0; ta[2] = 21'h100000; tlat[2] = RD_LAT; texp[2] = 8'h12;
      for (int i = 0; i < 3; i++) begin
         bit got = 0;
         bus3.req_valid = 1'b1; bus3.req_we = tw[i]; bus3.req_addr = ta[i]; bus3.req_wdata = 8'h77;
         for (int j = 0; j < 20 && !got; j++) begin
            @(negedge clk);
            if (bus3.req_ready) got = 1;
         end
         @(posedge clk); #1;
         bus3.req_valid = 1'b0;
         checks++;
         if (!got) begin errors++; $display("FAIL oob_accept idx=%0d ready=%b required=1", i, bus3.req_ready); end
         for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (we_n3 !== 3'b111 || doe3 !== 3'b000 || bus3.rsp_valid !== (k == tlat[i])) begin
               errors++;
               $display("FAIL oob_pins idx=%0d k=%0d we_n=%b doe=%b rsp=%b required 111 000 %0d",
                        i, k, we_n3, doe3, bus3.rsp_valid, (k == tlat[i]));
            end
            if (k == tlat[i]) begin
               checks++;
               if (bus3.rsp_rdata !== texp[i]) begin
                  errors++; $display("FAIL oob_rdata idx=%0d got=%h required=%h", i, bus3.rsp_rdata, texp[i]);
               end
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      int t;
      issue(1'b1, 20'h00777, 8'h3C, t);
      repeat (1 + WC) @(negedge clk);
      checks++;
      if (we_n !== 2'b10) begin
         errors++; $display("FAIL mid_strobe we_n=%b required=10", we_n);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (we_n !== 2'b11 || doe !== 2'b00 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset we_n=%b doe=%b rsp=%b ready=%b required 11 00 0 0", we_n, doe, bus.rsp_valid, bus.req_ready);
      end
      exp_q.delete();
      ref_mem.delete(key_of(0, 19'h00777));
      pin_mem.delete(key_of(0, 19'h00777));
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++; $display("FAIL mid_reset_ready got=%b required=1", bus.req_ready);
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_rsp k=%0d got=%b required=0", k, bus.rsp_valid);
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int ts [$];
      bit wes [8];
      int tt;
      int n0 = rsp_count;
      for (int i = 0; i < 8; i++) begin
         wes[i] = (i % 2) == 1;
         issue(wes[i], {1'($urandom_range(0, 1)), 19'($urandom_range(0, 7))}, 8'($urandom), tt);
         ts.push_back(tt);
      end
      wait_drain();
      for (int i = 1; i < 8; i++) begin
         checks++;
         if (ts[i] - ts[i-1] != (wes[i-1] ? WR_LAT : RD_LAT)) begin
            errors++;
            $display("FAIL b2b_spacing i=%0d got=%0d required=%0d", i, ts[i] - ts[i-1], (wes[i-1] ? WR_LAT : RD_LAT));
         end
      end
      checks++;
      if (rsp_count - n0 != 8) begin
         errors++; $display("FAIL b2b_rsp_count got=%0d required=8", rsp_count - n0);
      end
   endtask

   task automatic test_soak();
      int tt;
      int n0 = rsp_count;
      for (int i = 0; i < 2000; i++) begin
         issue(1'($urandom_range(0, 1)), {1'($urandom_range(0, 1)), 19'($urandom_range(0, 15))},
               8'($urandom), tt);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
         end
      end
      wait_drain();
      checks++;
      if (rsp_count - n0 != 2000) begin
         errors++; $display("FAIL soak_rsp_count got=%0d required=2000", rsp_count - n0);
      end
   endtask

   initial begin
      bus.req_valid  = 1'b0; bus.req_we  = 1'b0; bus.req_addr  = '0; bus.req_wdata  = '0;
      bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_addr = '0; bus3.req_wdata = '0;
      test_reset();
      test_write_timing();
      test_two_banks();
      test_oob();
      test_reset_mid();
      test_back_to_back();
      test_soak();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog time=%0t required=finish earlier", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
